instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Front end of the single-cycle MIPS core. It owns the PC, fetches each instruction from instruction memory over a req/ack handshake, and presents OpCode/Funct to the instruction-decode controller. It takes the controller's PCSource/Branch outputs plus register operands, resolves the next PC, and fetches again when the datapath retires the current instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 00.
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  reset; one clock; reset is asynchronous and active-low.
imem_req  output  1  fetch request.
imem_addr  output  32  fetch byte address, equal to pc.
imem_rdata  input  32  instruction word, sampled when imem_ack=1.
imem_ack  input  1  fetch complete; one-cycle pulse.
instr  output  32  held instruction register (IR).
instr_valid  output  1  IR valid; datapath may execute.
OpCode  output  6  IR[31:26] to controller.
Funct  output  6  IR[5:0] to controller.
PCSource  input  2  from controller: 10 jump, 01 beq, 00 sequential/other.
Branch  input  3  from controller: 100 beq, 101 bne, 110 blez, 111 bgtz, 001 bltz, 000 none.
rs_data  input  32  register rs value.
rt_data  input  32  register rt value.
retire  input  1  datapath completed current instruction.
pc  output  32  address of current instruction.
pc_plus4  output  32  pc+4, used as the jal/jalr link value.
misalign  output  1  sticky: jr/jalr target had nonzero bits [1:0].
instr_count  output  CNT_W  retired-instruction count.

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_PC, IR=0, instr_valid=0, imem_req=0, misalign=0, instr_count=0, state=FETCH.
- FSM with two states, FETCH and ISSUE.
- FETCH: imem_req=1 and imem_addr=pc, both held stable until imem_ack. On the cycle with ack: IR<=imem_rdata, go to ISSUE. In the next cycle instr_valid=1, req=0.
- Latency: at least 1 cycle from req to ack; ack in the first cycle of req is legal.
- imem_ack is ignored outside FETCH. retire is ignored in FETCH.
- ISSUE: instr_valid=1; IR, pc, OpCode and Funct are held stable. On retire: pc<=next_pc, instr_valid<=0, instr_count+=1 (wraps modulo 2^CNT_W), state<=FETCH. imem_req rises in the following cycle.
- Next-PC rules, in priority order:
  1. PCSource=10 and OpCode=0 (jr/jalr): rs_data with bits [1:0] forced to 00. If rs_data[1:0]!=0, set misalign=1 (sticky until reset).
  2. PCSource=10 and OpCode!=0 (j/jal): {pc_plus4[31:28], IR[25:0], 2'b00}.
  3. Branch!=000 and the branch condition is true: pc_plus4 + (signext(IR[15:0])<<2), 32-bit wrap.
     - beq: rs==rt. bne: rs!=rt.
     - blez: signed rs<=0. bgtz: signed rs>0. bltz: signed rs<0.
     - PCSource=01 with Branch=000 is treated as beq.
  4. Otherwise pc_plus4. PCSource=11 is treated as sequential.
- next_pc is combinational from IR and the inputs. It is sampled only on retire.
- Reset mid-fetch: imem_req drops asynchronously. An ack arriving while reset=0 is ignored. The first post-reset request is to RESET_PC.
- pc_plus4 = pc+4 with 32-bit wrap (0xFFFF_FFFC -> 0x0).

Decomposition:
- Shared package mips_pkg: opcode and funct constants; Branch codes (BR_NONE/BEQ/BNE/BLEZ/BGTZ/BLTZ); PCSource encodings (PCS_SEQ/PCS_BEQ/PCS_JUMP); FSM state encoding; RESET_PC default.
- One combinational sub-module, fetch_next_pc, computes branch-taken, the targets and next_pc. The top level holds the FSM, pc, IR, counter and misalign.

Test Plan:
- Hold reset=0 for 3 cycles -> pc=0, imem_req=0, instr_valid=0, instr_count=0. Release -> next edge imem_req=1, imem_addr=0.
- Ack after 3 cycles with rdata=0x2008_0005 (addi), then retire -> OpCode=0x08 while valid; then pc=4, imem_addr=4, instr_count=1.
- pc=0x10, IR imm16=0xFFFE, Branch=100, rs=rt=5, retire -> next fetch at 0x0C. Same with Branch=101 -> 0x14.
- rs=0x8000_0000, imm16=0x0004, pc=0x20 -> blez and bltz fetch 0x34, bgtz fetches 0x24. With rs=0, bgtz fetches 0x24 and blez fetches 0x34.
- pc=0x1000_0010, IR=0x0800_0040 (j), PCSource=10 -> 0x1000_0100. Then jr (IR=0x0120_0008) with rs=0x0000_0203 -> pc=0x200, misalign=1.
- Assert reset mid-FETCH with an ack pulse issued during reset -> ack ignored; after release, imem_addr=RESET_PC and instr_count=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encodings for the fetch front end: opcodes, functs, controller
// branch/PC-source codes and the fetch FSM state type.
package mips_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDI   = 6'h08;

   localparam logic [5:0] FN_JR     = 6'h08;
   localparam logic [5:0] FN_JALR   = 6'h09;

   localparam logic [2:0] BR_NONE = 3'b000;
   localparam logic [2:0] BR_BEQ  = 3'b100;
   localparam logic [2:0] BR_BNE  = 3'b101;
   localparam logic [2:0] BR_BLEZ = 3'b110;
   localparam logic [2:0] BR_BGTZ = 3'b111;
   localparam logic [2:0] BR_BLTZ = 3'b001;

   localparam logic [1:0] PCS_SEQ  = 2'b00;
   localparam logic [1:0] PCS_BEQ  = 2'b01;
   localparam logic [1:0] PCS_JUMP = 2'b10;

   typedef enum logic {
      FETCH = 1'b0,
      ISSUE = 1'b1
   } fetchState_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC resolution: branch condition, jump/jr/branch targets
// and the final priority mux.
module fetch_next_pc
   import mips_pkg::*;
(
   input  logic [31:0] pcPlus4,
   input  logic [31:0] ir,
   input  logic [1:0]  pcSource,
   input  logic [2:0]  branch,
   input  logic [31:0] rsData,
   input  logic [31:0] rtData,
   output logic [31:0] nextPc,
   output logic        jrMisalign
);

   logic [2:0]  brEff;
   logic        branchTaken;
   logic        isJump;
   logic        isJr;
   logic [31:0] brTarget;
   logic [31:0] jTarget;
   logic [31:0] jrTarget;

   assign isJump   = (pcSource == PCS_JUMP);
   assign isJr     = isJump && (ir[31:26] == OP_RTYPE);
   assign brTarget = pcPlus4 + {{14{ir[15]}}, ir[15:0], 2'b00};
   assign jTarget  = {pcPlus4[31:28], ir[25:0], 2'b00};
   assign jrTarget = {rsData[31:2], 2'b00};
   assign jrMisalign = isJr && (rsData[1:0] != 2'b00);

   // A bare PCSource=01 from the controller still means beq
   always_comb begin
      brEff = branch;
      if (branch == BR_NONE && pcSource == PCS_BEQ)
         brEff = BR_BEQ;
   end

   always_comb begin
      branchTaken = 1'b0;
      case (brEff)
         BR_BEQ:  branchTaken = (rsData == rtData);
         BR_BNE:  branchTaken = (rsData != rtData);
         BR_BLEZ: branchTaken = rsData[31] || (rsData == 32'd0);
         BR_BGTZ: branchTaken = !rsData[31] && (rsData != 32'd0);
         BR_BLTZ: branchTaken = rsData[31];
         default: branchTaken = 1'b0;
      endcase
   end

   always_comb begin
      nextPc = pcPlus4;
      if (isJr)
         nextPc = jrTarget;
      else if (isJump)
         nextPc = jTarget;
      else if (branchTaken)
         nextPc = brTarget;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS fetch front end: owns PC and IR, runs the imem req/ack handshake and
// advances the PC when the datapath retires the held instruction.
//
//   state | meaning
//   FETCH | imem_req held at pc until imem_ack; IR captured on ack
//   ISSUE | IR valid and stable; waiting for retire to load next_pc
module instr_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_rdata,
   input  logic             imem_ack,
   output logic [31:0]      instr,
   output logic             instr_valid,
   output logic [5:0]       OpCode,
   output logic [5:0]       Funct,
   input  logic [1:0]       PCSource,
   input  logic [2:0]       Branch,
   input  logic [31:0]      rs_data,
   input  logic [31:0]      rt_data,
   input  logic             retire,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   output logic             misalign,
   output logic [CNT_W-1:0] instr_count
);

   fetchState_t state;
   fetchState_t stateNext;
   logic        reqQ;
   logic        ackTake;
   logic        retireTake;
   logic [31:0] nextPc;
   logic        jrMisalign;

   // reqQ is registered so it rises one edge after reset release or retire
   assign ackTake    = (state == FETCH) && reqQ && imem_ack;
   assign retireTake = (state == ISSUE) && retire;

   assign imem_req    = reqQ;
   assign imem_addr   = pc;
   assign instr_valid = (state == ISSUE);
   assign OpCode      = instr[31:26];
   assign Funct       = instr[5:0];
   assign pc_plus4    = pc + 32'd4;

   fetch_next_pc u_nextPc (
      .pcPlus4    (pc_plus4),
      .ir         (instr),
      .pcSource   (PCSource),
      .branch     (Branch),
      .rsData     (rs_data),
      .rtData     (rt_data),
      .nextPc     (nextPc),
      .jrMisalign (jrMisalign)
   );

   always_comb begin
      stateNext = state;
      case (state)
         FETCH:   if (ackTake) stateNext = ISSUE;
         ISSUE:   if (retireTake) stateNext = FETCH;
         default: stateNext = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= FETCH;
         reqQ        <= 1'b0;
         pc          <= RESET_PC;
         instr       <= 32'd0;
         misalign    <= 1'b0;
         instr_count <= '0;
      end else begin
         state <= stateNext;
         reqQ  <= (stateNext == FETCH);
         if (ackTake)
            instr <= imem_rdata;
         if (retireTake) begin
            pc          <= nextPc;
            instr_count <= instr_count + CNT_W'(1);
            if (jrMisalign)
               misalign <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset/handshake sequences plus a
// table of next-PC vectors, each reached by first jumping pc to a known value.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'd0;
   logic        imem_ack = 1'b0;
   logic [31:0] instr;
   logic        instr_valid;
   logic [5:0]  OpCode;
   logic [5:0]  Funct;
   logic [1:0]  PCSource = 2'b00;
   logic [2:0]  Branch = 3'b000;
   logic [31:0] rs_data = 32'd0;
   logic [31:0] rt_data = 32'd0;
   logic        retire = 1'b0;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        misalign;
   logic [31:0] instr_count;

   int checks = 0;
   int errors = 0;
   logic [31:0] expCount = 32'd0;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_ack(imem_ack),
      .instr(instr), .instr_valid(instr_valid),
      .OpCode(OpCode), .Funct(Funct),
      .PCSource(PCSource), .Branch(Branch),
      .rs_data(rs_data), .rt_data(rt_data),
      .retire(retire), .pc(pc), .pc_plus4(pc_plus4),
      .misalign(misalign), .instr_count(instr_count)
   );

   typedef struct {
      logic [31:0] startPc;
      logic [31:0] ir;
      logic [1:0]  pcs;
      logic [2:0]  br;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] expPc;
      logic        expMis;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for imem_req, holds ack low for lat cycles, then acks
   task automatic doFetch(input logic [31:0] rdata, input int lat);
      int n = 0;
      while (!imem_req && n < 20) begin
         step();
         n++;
      end
      chk("req_timeout", {31'd0, imem_req}, 32'd1);
      for (int k = 0; k < lat; k++) begin
         step();
         chk("req_held", {31'd0, imem_req}, 32'd1);
      end
      imem_rdata = rdata;
      imem_ack   = 1'b1;
      step();
      imem_ack   = 1'b0;
      imem_rdata = 32'hBAD0_BAD0;
   endtask

   task automatic doRetire(input logic [1:0] pcs, input logic [2:0] br,
                           input logic [31:0] rs, input logic [31:0] rt);
      PCSource = pcs;
      Branch   = br;
      rs_data  = rs;
      rt_data  = rt;
      retire   = 1'b1;
      step();
      retire   = 1'b0;
      PCSource = 2'b00;
      Branch   = 3'b000;
      expCount = expCount + 32'd1;
   endtask

   initial begin
      vecs[0]  = '{32'h0000_0010, 32'h1000_FFFE, 2'b01, 3'b100, 32'd5, 32'd5, 32'h0000_000C, 1'b0};
      vecs[1]  = '{32'h0000_0010, 32'h1400_FFFE, 2'b00, 3'b101, 32'd5, 32'd5, 32'h0000_0014, 1'b0};
      vecs[2]  = '{32'h0000_0020, 32'h1800_0004, 2'b00, 3'b110, 32'h8000_0000, 32'd0, 32'h0000_0034, 1'b0};
      vecs[3]  = '{32'h0000_0020, 32'h0400_0004, 2'b00, 3'b001, 32'h8000_0000, 32'd0, 32'h0000_0034, 1'b0};
      vecs[4]  = '{32'h0000_0020, 32'h1C00_0004, 2'b00, 3'b111, 32'h8000_0000, 32'd0, 32'h0000_0024, 1'b0};
      vecs[5]  = '{32'h0000_0020, 32'h1C00_0004, 2'b00, 3'b111, 32'd0, 32'd0, 32'h0000_0024, 1'b0};
      vecs[6]  = '{32'h0000_0020, 32'h1800_0004, 2'b00, 3'b110, 32'd0, 32'd0, 32'h0000_0034, 1'b0};
      vecs[7]  = '{32'h0000_0040, 32'h1000_0003, 2'b01, 3'b000, 32'd7, 32'd7, 32'h0000_0050, 1'b0};
      vecs[8]  = '{32'h0000_0040, 32'h1000_0003, 2'b11, 3'b000, 32'd7, 32'd7, 32'h0000_0044, 1'b0};
      vecs[9]  = '{32'hFFFF_FFFC, 32'h2008_0001, 2'b00, 3'b000, 32'd0, 32'd0, 32'h0000_0000, 1'b0};
      vecs[10] = '{32'h1000_0010, 32'h0800_0040, 2'b10, 3'b100, 32'd1, 32'd1, 32'h1000_0100, 1'b0};
      vecs[11] = '{32'h0000_0100, 32'h0120_0008, 2'b10, 3'b000, 32'h0000_0203, 32'd0, 32'h0000_0200, 1'b1};

      // Reset held for 3 cycles
      reset = 1'b0;
      repeat (3) step();
      chk("rst_pc", pc, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_count", instr_count, 32'd0);
      chk("rst_misalign", {31'd0, misalign}, 32'd0);
      reset = 1'b1;
      step();
      chk("post_rst_req", {31'd0, imem_req}, 32'd1);
      chk("post_rst_addr", imem_addr, 32'd0);

      // First fetch with 3-cycle latency
      doFetch(32'h2008_0005, 3);
      chk("addi_valid", {31'd0, instr_valid}, 32'd1);
      chk("addi_req_low", {31'd0, imem_req}, 32'd0);
      chk("addi_opcode", {26'd0, OpCode}, 32'h08);
      chk("addi_funct", {26'd0, Funct}, 32'h05);
      chk("addi_instr", instr, 32'h2008_0005);
      imem_ack = 1'b1;
      imem_rdata = 32'hFFFF_FFFF;
      step();
      imem_ack = 1'b0;
      chk("ack_ignored_issue", instr, 32'h2008_0005);
      doRetire(2'b00, 3'b000, 32'd0, 32'd0);
      chk("addi_pc", pc, 32'd4);
      chk("addi_count", instr_count, expCount);
      chk("addi_valid_low", {31'd0, instr_valid}, 32'd0);
      step();
      chk("addi_req_again", {31'd0, imem_req}, 32'd1);
      chk("addi_addr", imem_addr, 32'd4);

      for (int i = 0; i < 12; i++) begin
         // Position pc with an aligned jr
         doFetch(32'h0000_0008, i % 3);
         doRetire(2'b10, 3'b000, vecs[i].startPc, 32'd0);
         doFetch(vecs[i].ir, (i + 1) % 3);
         chk($sformatf("v%0d_pc", i), pc, vecs[i].startPc);
         chk($sformatf("v%0d_pc4", i), pc_plus4, vecs[i].startPc + 32'd4);
         chk($sformatf("v%0d_opcode", i), {26'd0, OpCode}, {26'd0, vecs[i].ir[31:26]});
         chk($sformatf("v%0d_funct", i), {26'd0, Funct}, {26'd0, vecs[i].ir[5:0]});
         doRetire(vecs[i].pcs, vecs[i].br, vecs[i].rs, vecs[i].rt);
         chk($sformatf("v%0d_nextpc", i), pc, vecs[i].expPc);
         chk($sformatf("v%0d_misalign", i), {31'd0, misalign}, {31'd0, vecs[i].expMis});
         step();
         chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].expPc);
      end
      chk("count_total", instr_count, expCount);

      // Reset mid-fetch with an ack pulse during reset
      chk("midrst_req_before", {31'd0, imem_req}, 32'd1);
      reset = 1'b0;
      #1;
      chk("midrst_req_async", {31'd0, imem_req}, 32'd0);
      chk("midrst_pc", pc, 32'd0);
      imem_rdata = 32'hDEAD_BEEF;
      imem_ack   = 1'b1;
      step();
      imem_ack   = 1'b0;
      step();
      chk("midrst_ir", instr, 32'd0);
      chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
      reset = 1'b1;
      step();
      chk("midrst_req_after", {31'd0, imem_req}, 32'd1);
      chk("midrst_addr", imem_addr, 32'd0);
      chk("midrst_count", instr_count, 32'd0);
      chk("midrst_misalign", {31'd0, misalign}, 32'd0);
      doFetch(32'h2008_0005, 0);
      chk("midrst_refetch", instr, 32'h2008_0005);
      chk("midrst_refetch_valid", {31'd0, instr_valid}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
